alu_wb32: RTL
=============

ALU_WB32 -- requirements
Module: alu_wb32

Interface
REQ-001 SHALL have parameter DEPTH, default 2, queue entries (power of two, >= 2).
REQ-002 SHALL have parameter NREG, default 16, register-file entries; RW = log2(NREG).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  arithmetic unit presents a result.
REQ-006 SHALL have port in_ready  output  1  block accepts the result this cycle.
REQ-007 SHALL have port in_res  input  32  result word from inc/dec/add/sub/adf units.
REQ-008 SHALL have port in_flg  input  3  flags: [0] zero, [1] overflow, [2] carry.
REQ-009 SHALL have port in_dst  input  RW  destination register index.
REQ-010 SHALL have port in_regwe  input  1  result is to be written to the register file.
REQ-011 SHALL have port in_flgwe  input  1  flags are to be written to msw.
REQ-012 SHALL have port rf_we  output  1  register-file write request.
REQ-013 SHALL have port rf_addr  output  RW  write index.
REQ-014 SHALL have port rf_data  output  32  write data.
REQ-015 SHALL have port rf_ack  input  1  register file accepts the write this cycle.
REQ-016 SHALL have port msw_clr  input  1  one-cycle pulse clearing msw flag bits.
REQ-017 SHALL have port msw  output  32  machine status word.
REQ-018 SHALL have port cnt  output  log2(DEPTH)+1  queued entry count.

Function
REQ-019 SHALL push {in_res, in_flg, in_dst, in_regwe, in_flgwe} on a clock edge where in_valid && in_ready.
REQ-020 SHALL drive in_ready = (cnt != DEPTH), combinational from registered state only; no pass-through when full.
REQ-021 SHALL expose a pushed entry at the head no earlier than the cycle after the push (latency 1 from accept to rf_we).
REQ-022 SHALL drive rf_we = (cnt != 0) && head.regwe, with rf_addr/rf_data from the head; held stable until popped.
REQ-023 SHALL pop the head on an edge where cnt != 0 and (rf_ack || !head.regwe); entries with regwe=0 retire in one cycle.
REQ-024 SHALL, on a pop with head.flgwe=1, load msw[2:0] <= head.flg on the same edge.
REQ-025 SHALL, on msw_clr=1, clear msw[2:0]; when coinciding with a flag-updating pop, the pop value wins.
REQ-026 SHALL hold msw[31:3] at zero.
REQ-027 SHALL support simultaneous push and pop when 0 < cnt < DEPTH: cnt unchanged, order preserved.
REQ-028 SHALL retire entries strictly in acceptance order.
REQ-029 SHALL wrap read/write pointers modulo DEPTH; cnt SHALL never exceed DEPTH nor underflow.
REQ-030 SHALL ignore rf_ack when rf_we=0.

Reset
REQ-031 SHALL, while rst=1, force pointers and cnt to 0, msw to 0, rf_we to 0; in_ready=1.
REQ-032 SHALL discard queued entries on rst asserted mid-operation; no write is issued for them.
REQ-033 SHALL accept a push on the first rising edge after rst deasserts.

Structure
REQ-034 SHALL take flag bit indices (ZF=0, OF=1, CF=2), MSW width and the queue-entry type from shared package arith_pkg.
REQ-035 SHALL implement storage in one sub-module wbq_fifo (parameterised DEPTH, entry width); msw logic stays in alu_wb32.

Verification
REQ-036 SHALL cover: push res=0x0000_0005 dst=3 regwe=1 flgwe=1 flg=3'b000, rf_ack=1 -> rf_we=1 addr=3 data=5 one cycle later; msw[2:0]=000 after pop.
REQ-037 SHALL cover: rf_ack=0, push 3 entries with DEPTH=2 -> first two accepted, in_ready=0, cnt=2; rf_ack=1 -> retire in order, third accepted.
REQ-038 SHALL cover: push flg=3'b100 (carry) regwe=0 flgwe=1 -> popped next cycle with rf_we=0, msw=0x0000_0004.
REQ-039 SHALL cover: msw=0x0000_0006, msw_clr=1 same edge as pop with flg=3'b001 -> msw=0x0000_0001; msw_clr alone -> msw=0.
REQ-040 SHALL cover: rst asserted asynchronously with cnt=2 -> immediately cnt=0, rf_we=0, msw=0, in_ready=1; 10 push/pop cycles wrap pointers with data intact.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: flag bit positions, word widths and
// the write-back queue entry payload (destination index appended by the user).
package arith_pkg;

  localparam int ZF    = 0;
  localparam int OF    = 1;
  localparam int CF    = 2;
  localparam int FLG_W = 3;
  localparam int RES_W = 32;
  localparam int MSW_W = 32;

  typedef struct packed {
    logic [RES_W-1:0] res;
    logic [FLG_W-1:0] flg;
    logic             regwe;
    logic             flgwe;
  } wbq_ent_t;

endpackage

// File: rtl/wbq_fifo.sv
// Power-of-two circular queue with registered head; a pushed
// word becomes visible at the head on the following cycle.
module wbq_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic [AW:0]  cnt_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam logic [AW-1:0] PONE = AW'(1);
  localparam logic [AW:0]   CONE = (AW+1)'(1);
  localparam logic [AW:0]   CMAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CMAX);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PONE;
      if (pop_ok)  rptr_q <= rptr_q + PONE;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CONE;
        2'b01:   cnt_q <= cnt_q - CONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: cnt/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_wb32.sv
// Arithmetic write-back stage: queues unit results, drains them to the
// register file in order and folds retired flags into the status word.
module alu_wb32
  import arith_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int NREG  = 16,
  localparam int RW    = $clog2(NREG),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_res,
  input  logic [FLG_W-1:0] in_flg,
  input  logic [RW-1:0]    in_dst,
  input  logic             in_regwe,
  input  logic             in_flgwe,
  output logic             rf_we,
  output logic [RW-1:0]    rf_addr,
  output logic [RES_W-1:0] rf_data,
  input  logic             rf_ack,
  input  logic             msw_clr,
  output logic [MSW_W-1:0] msw,
  output logic [CW-1:0]    cnt
);

  localparam int EW = $bits(wbq_ent_t) + RW;

  wbq_ent_t         in_ent, hd_ent;
  logic [RW-1:0]    hd_dst;
  logic [EW-1:0]    q_rdata;
  logic             q_full, q_empty;
  logic             push, pop;
  logic [FLG_W-1:0] flg_q, flg_d;

  assign in_ent = '{res: in_res, flg: in_flg,
                    regwe: in_regwe, flgwe: in_flgwe};

  wbq_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_ent, in_dst}),
    .rdata_o (q_rdata),
    .cnt_o   (cnt),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign {hd_ent, hd_dst} = q_rdata;

  assign in_ready = !q_full;
  assign push     = in_valid && in_ready;
  assign rf_we    = !q_empty && hd_ent.regwe;
  assign rf_addr  = hd_dst;
  assign rf_data  = hd_ent.res;
  // Flag-only entries never wait on the register file.
  assign pop      = !q_empty && (rf_ack || !hd_ent.regwe);

  always_comb begin
    flg_d = flg_q;
    if (pop && hd_ent.flgwe) flg_d = hd_ent.flg;
    else if (msw_clr)        flg_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flg_q <= '0;
    else     flg_q <= flg_d;
  end

  always_comb begin
    msw     = '0;
    msw[ZF] = flg_q[ZF];
    msw[OF] = flg_q[OF];
    msw[CF] = flg_q[CF];
  end

endmodule
